dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, data-memory address width.
REQ-002 SHALL have parameter DW, default 16, data-memory word width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req_a/req_b  input  1  access request, port A (pipeline MEM stage) / port B (loader/debug).
REQ-006 SHALL have ports we_a/we_b  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports lock_a/lock_b  input  1  hold memory ownership after this access.
REQ-008 SHALL have ports addr_a/addr_b  input  AW  word address.
REQ-009 SHALL have ports wdata_a/wdata_b  input  DW  write data.
REQ-010 SHALL have ports gnt_a/gnt_b  output  1  access accepted this cycle (combinational).
REQ-011 SHALL have ports rvalid_a/rvalid_b  output  1  read data valid, one-cycle pulse.
REQ-012 SHALL have ports rdata_a/rdata_b  output  DW  registered read data.
REQ-013 SHALL have ports mem_addr (AW), mem_dataw (DW), mem_read (1), mem_write (1)  output  memory-side controls.
REQ-014 SHALL have port mem_data  input  DW  combinational memory read data.

Function
REQ-015 An access SHALL complete in the cycle where req_x && gnt_x; requester holds req/we/lock/addr/wdata stable until granted.
REQ-016 At most one of gnt_a/gnt_b SHALL be high in any cycle; gnt_x SHALL never be high without req_x.
REQ-017 Single requester, no lock owner: that requester SHALL be granted the same cycle.
REQ-018 Both requesting, no lock owner: grant SHALL go to the port not granted most recently (round-robin, 1-bit last_gnt register, updated on every grant).
REQ-019 Lock owner register SHALL be set to port x when x is granted with lock_x=1; cleared when owner is granted with lock_x=0 or owner drops req_x.
REQ-020 While a lock owner exists, only the owner SHALL be granted; the other port waits regardless of round-robin state.
REQ-021 Granted cycle: mem_addr/mem_dataw SHALL mux the granted port; mem_write = we; mem_read = ~we.
REQ-022 No grant: mem_read=0, mem_write=0, mem_addr=0, mem_dataw=0.
REQ-023 Granted read: mem_data SHALL be captured into rdata_x at that clock edge; rvalid_x high exactly the following cycle.
REQ-024 rdata_x SHALL hold its value until the next read on port x; rvalid_x low otherwise.
REQ-025 Granted write: no rvalid pulse; memory commits on the same edge.
REQ-026 Back-to-back reads on one port SHALL sustain one access per cycle (rvalid_x continuously high).
REQ-027 Address wrap: full AW range valid, no out-of-range handling.

Reset
REQ-028 Asynchronous on rst_n low: rvalid_a/b=0, rdata_a/b=0, lock owner cleared, last_gnt=B (A wins first contention).
REQ-029 Reset mid-access SHALL drop any pending rvalid; gnt/mem controls follow REQ-017..022 from reset state immediately.

Structure
REQ-030 Package dm_arb_pkg SHALL hold AW, DW defaults and port-id enum (PORT_A, PORT_B, PORT_NONE).
REQ-031 Grant logic SHALL be sub-module rr_arb2 (req, lock owner, last_gnt in; one-hot grant out); capture registers and mux in dm_arbiter.

Verification (memory preloaded: [0]=0x0008, [4]=0x001A, [10]=0x000B)
REQ-032 After reset, req_a read addr 0x04 alone -> gnt_a same cycle, mem_read=1, next cycle rvalid_a=1, rdata_a=0x001A.
REQ-033 Both read (A addr 0x00, B addr 0x0A) continuously -> grants alternate A,B,A; rdata_a=0x0008, rdata_b=0x000B, one-cycle lag each.
REQ-034 A write 0x1234 to 0x05, then B read 0x05 -> mem_write pulse one cycle, rdata_b=0x1234.
REQ-035 B read 0x04 with lock_b=1, then B write 0x001B lock_b=0, A requesting throughout -> A blocked both cycles, granted third cycle; A read 0x04 returns 0x001B.
REQ-036 rst_n low during A read grant cycle -> no rvalid_a next cycle, rdata_a=0, lock cleared; next contention grants A.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
package dm_arb_pkg;

  localparam int unsigned AW_DEFAULT = 8;
  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    PORT_A    = 2'd0,
    PORT_B    = 2'd1,
    PORT_NONE = 2'd2
  } port_id_e;

  // Ownership that results from granting a port: it keeps the memory only if it asked to.
  function automatic port_id_e owner_after_grant(input logic lock, input port_id_e port);
    return lock ? port : PORT_NONE;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way grant decision: a lock owner gets exclusive access, otherwise a
// lone requester wins and contention goes to the port not granted last.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  port_id_e   lock_owner,
  input  logic       last_gnt_b,
  output logic [1:0] gnt
);

  // One-hot grant, bit 0 = port A, bit 1 = port B.
  always_comb begin
    gnt = 2'b00;
    case (lock_owner)
      PORT_A:  gnt[0] = req_a;
      PORT_B:  gnt[1] = req_b;
      default: begin
        if (req_a && req_b) begin
          gnt = last_gnt_b ? 2'b01 : 2'b10;
        end else begin
          gnt = {req_b, req_a};
        end
      end
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (port A) and a
// loader/debug port (port B). Grants are combinational; read data is
// registered and flagged with a one-cycle rvalid pulse on the requesting port.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic          lock_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dataw,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_data
);

  port_id_e      lock_owner_q, lock_owner_d;
  logic          last_gnt_b_q, last_gnt_b_d;
  logic          rvalid_a_q, rvalid_a_d;
  logic          rvalid_b_q, rvalid_b_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic [1:0]    gnt_vec;

  rr_arb2 u_rr_arb2 (
    .req_a      (req_a),
    .req_b      (req_b),
    .lock_owner (lock_owner_q),
    .last_gnt_b (last_gnt_b_q),
    .gnt        (gnt_vec)
  );

  assign gnt_a    = gnt_vec[0];
  assign gnt_b    = gnt_vec[1];
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

  // Steer the granted port onto the memory bus; idle bus is all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_dataw = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt_a) begin
      mem_addr  = addr_a;
      mem_dataw = wdata_a;
      mem_write = we_a;
      mem_read  = ~we_a;
    end else if (gnt_b) begin
      mem_addr  = addr_b;
      mem_dataw = wdata_b;
      mem_write = we_b;
      mem_read  = ~we_b;
    end
  end

  // Ownership and round-robin bookkeeping; an owner that stops requesting gives up the lock.
  always_comb begin
    lock_owner_d = lock_owner_q;
    last_gnt_b_d = last_gnt_b_q;
    if (gnt_a) begin
      lock_owner_d = owner_after_grant(lock_a, PORT_A);
      last_gnt_b_d = 1'b0;
    end else if (gnt_b) begin
      lock_owner_d = owner_after_grant(lock_b, PORT_B);
      last_gnt_b_d = 1'b1;
    end else if ((lock_owner_q == PORT_A && !req_a) ||
                 (lock_owner_q == PORT_B && !req_b)) begin
      lock_owner_d = PORT_NONE;
    end
  end

  // Read capture: memory data is sampled on the grant edge, rdata holds until the next read.
  always_comb begin
    rvalid_a_d = gnt_a && !we_a;
    rvalid_b_d = gnt_b && !we_b;
    rdata_a_d  = rvalid_a_d ? mem_data : rdata_a_q;
    rdata_b_d  = rvalid_b_d ? mem_data : rdata_b_q;
  end

  // State registers; after reset port B counts as last granted so A wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_owner_q <= PORT_NONE;
      last_gnt_b_q <= 1'b1;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      lock_owner_q <= lock_owner_d;
      last_gnt_b_q <= last_gnt_b_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_dm_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    bit            req;
    bit            we;
    bit            lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, we_a, lock_a, req_b, we_b, lock_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataw;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  req_t cur_a, cur_b;

  // Model state: lock owner (0 none, 1 A, 2 B), who wins the next contention,
  // pending read results, and the memory contents as the model believes them.
  int            m_owner = 0;
  bit            m_a_wins = 1'b1;
  bit            m_rv_a = 1'b0, m_rv_b = 1'b0;
  logic [DW-1:0] m_rd_a = '0, m_rd_b = '0;
  bit            mg_a = 1'b0, mg_b = 1'b0;
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] dev_mem [0:255];

  always #5 clk = ~clk;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .we_a      (we_a),
    .lock_a    (lock_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .lock_b    (lock_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .rvalid_a  (rvalid_a),
    .rvalid_b  (rvalid_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .mem_addr  (mem_addr),
    .mem_dataw (mem_dataw),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_data  (mem_data)
  );

  function automatic logic [DW-1:0] preloadVal(input int i);
    if (i == 0)  return 16'h0008;
    if (i == 4)  return 16'h001A;
    if (i == 10) return 16'h000B;
    return 16'((i * 37) ^ 16'h5A00);
  endfunction

  // Memory device: combinational read, write committed on the clock edge.
  assign mem_data = dev_mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) dev_mem[i] = preloadVal(i);
    forever begin
      @(posedge clk);
      if (mem_write) dev_mem[mem_addr] = mem_dataw;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input req_t a, input req_t b);
    req_a = a.req; we_a = a.we; lock_a = a.lock; addr_a = a.addr; wdata_a = a.wdata;
    req_b = b.req; we_b = b.we; lock_b = b.lock; addr_b = b.addr; wdata_b = b.wdata;
  endtask

  function automatic req_t mk(input bit req, input bit we, input bit lock,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_t r;
    r.req = req; r.we = we; r.lock = lock; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t randReq();
    req_t r;
    int   kind;
    r.req  = ($urandom_range(0, 9) < 6);
    r.we   = ($urandom_range(0, 2) == 0);
    r.lock = ($urandom_range(0, 3) == 0);
    kind   = int'($urandom_range(0, 3));
    r.addr = (kind == 0) ? 8'h00 : (kind == 1) ? 8'hFF : 8'($urandom_range(0, 255));
    r.wdata = 16'($urandom);
    return r;
  endfunction

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model, then advance the model across the next edge.
  initial begin
    bit            ea, eb;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dataw;
    bit            e_rd, e_wr;
    for (int i = 0; i < 256; i++) ref_mem[i] = preloadVal(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_owner = 0; m_a_wins = 1'b1;
        m_rv_a = 1'b0; m_rv_b = 1'b0; m_rd_a = '0; m_rd_b = '0;
      end
      ea = 1'b0; eb = 1'b0;
      if (m_owner == 1)      ea = req_a;
      else if (m_owner == 2) eb = req_b;
      else if (req_a && req_b) begin ea = m_a_wins; eb = !m_a_wins; end
      else begin ea = req_a; eb = req_b; end
      e_addr = '0; e_dataw = '0; e_rd = 1'b0; e_wr = 1'b0;
      if (ea) begin e_addr = addr_a; e_dataw = wdata_a; e_wr = we_a; e_rd = !we_a; end
      if (eb) begin e_addr = addr_b; e_dataw = wdata_b; e_wr = we_b; e_rd = !we_b; end
      checkOutput("gnt_a",     32'(gnt_a),     32'(ea));
      checkOutput("gnt_b",     32'(gnt_b),     32'(eb));
      checkOutput("mem_read",  32'(mem_read),  32'(e_rd));
      checkOutput("mem_write", 32'(mem_write), 32'(e_wr));
      checkOutput("mem_addr",  32'(mem_addr),  32'(e_addr));
      checkOutput("mem_dataw", 32'(mem_dataw), 32'(e_dataw));
      checkOutput("rvalid_a",  32'(rvalid_a),  32'(m_rv_a));
      checkOutput("rvalid_b",  32'(rvalid_b),  32'(m_rv_b));
      checkOutput("rdata_a",   32'(rdata_a),   32'(m_rd_a));
      checkOutput("rdata_b",   32'(rdata_b),   32'(m_rd_b));
      mg_a = ea; mg_b = eb;
      if (rst_n) begin
        m_rv_a = ea && !we_a;
        m_rv_b = eb && !we_b;
        if (m_rv_a) m_rd_a = ref_mem[addr_a];
        if (m_rv_b) m_rd_b = ref_mem[addr_b];
        if (ea) begin m_owner = lock_a ? 1 : 0; m_a_wins = 1'b0; end
        else if (eb) begin m_owner = lock_b ? 2 : 0; m_a_wins = 1'b1; end
        else if ((m_owner == 1 && !req_a) || (m_owner == 2 && !req_b)) m_owner = 0;
      end
      if (ea && we_a) ref_mem[addr_a] = wdata_a;
      if (eb && we_b) ref_mem[addr_b] = wdata_b;
    end
  end

  initial begin
    req_t idle;
    idle = mk(0, 0, 0, 8'h00, 16'h0000);
    rst_n = 1'b0;
    applyStimulus(idle, idle);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rvalid_a", 32'(rvalid_a), 32'd0);
    checkOutput("reset_rdata_b",  32'(rdata_b),  32'd0);
    rst_n = 1'b1;

    // Lone read on A after reset
    applyStimulus(mk(1, 0, 0, 8'h04, 16'h0), idle);
    settle();
    checkOutput("r032_gnt_a",    32'(gnt_a),    32'd1);
    checkOutput("r032_mem_read", 32'(mem_read), 32'd1);
    checkOutput("r032_mem_addr", 32'(mem_addr), 32'h04);
    stepEdge();
    applyStimulus(idle, idle);
    settle();
    checkOutput("r032_rvalid_a", 32'(rvalid_a), 32'd1);
    checkOutput("r032_rdata_a",  32'(rdata_a),  32'h001A);
    checkOutput("idle_mem_read", 32'(mem_read), 32'd0);

    // A write then B read of the same word
    stepEdge();
    applyStimulus(mk(1, 1, 0, 8'h05, 16'h1234), idle);
    settle();
    checkOutput("r034_mem_write", 32'(mem_write), 32'd1);
    checkOutput("r034_mem_dataw", 32'(mem_dataw), 32'h1234);
    stepEdge();
    applyStimulus(idle, mk(1, 0, 0, 8'h05, 16'h0));
    settle();
    checkOutput("r034_no_rvalid_a", 32'(rvalid_a),  32'd0);
    checkOutput("r034_write_pulse", 32'(mem_write), 32'd0);
    checkOutput("r034_gnt_b",       32'(gnt_b),     32'd1);
    stepEdge();
    applyStimulus(idle, idle);
    settle();
    checkOutput("r034_rdata_b", 32'(rdata_b), 32'h1234);

    // Continuous contention, B granted last so A goes first
    stepEdge();
    applyStimulus(mk(1, 0, 0, 8'h00, 16'h0), mk(1, 0, 0, 8'h0A, 16'h0));
    settle();
    checkOutput("r033_c1_gnt_a", 32'(gnt_a), 32'd1);
    stepEdge();
    settle();
    checkOutput("r033_c2_gnt_b",   32'(gnt_b),   32'd1);
    checkOutput("r033_c2_rdata_a", 32'(rdata_a), 32'h0008);
    stepEdge();
    settle();
    checkOutput("r033_c3_gnt_a",    32'(gnt_a),    32'd1);
    checkOutput("r033_c3_rvalid_b", 32'(rvalid_b), 32'd1);
    checkOutput("r033_c3_rdata_b",  32'(rdata_b),  32'h000B);
    stepEdge();
    applyStimulus(idle, idle);
    settle();

    // Locked read-modify-write on B with A waiting
    stepEdge();
    applyStimulus(mk(1, 0, 0, 8'h04, 16'h0), mk(1, 0, 1, 8'h04, 16'h0));
    settle();
    checkOutput("r035_c1_gnt_a", 32'(gnt_a), 32'd0);
    stepEdge();
    applyStimulus(mk(1, 0, 0, 8'h04, 16'h0), mk(1, 1, 0, 8'h04, 16'h001B));
    settle();
    checkOutput("r035_c2_gnt_a",   32'(gnt_a),   32'd0);
    checkOutput("r035_c2_gnt_b",   32'(gnt_b),   32'd1);
    checkOutput("r035_c2_rdata_b", 32'(rdata_b), 32'h001A);
    stepEdge();
    applyStimulus(mk(1, 0, 0, 8'h04, 16'h0), idle);
    settle();
    checkOutput("r035_c3_gnt_a", 32'(gnt_a), 32'd1);
    stepEdge();
    applyStimulus(idle, idle);
    settle();
    checkOutput("r035_rdata_a", 32'(rdata_a), 32'h001B);

    // Reset during a grant: pending data dropped, lock and round-robin restored
    stepEdge();
    applyStimulus(idle, mk(1, 0, 1, 8'h0A, 16'h0));
    settle();
    stepEdge();
    applyStimulus(mk(1, 0, 0, 8'h00, 16'h0), mk(1, 0, 1, 8'h0A, 16'h0));
    rst_n = 1'b0;
    settle();
    checkOutput("r036_rst_gnt_a",    32'(gnt_a),    32'd1);
    checkOutput("r036_rst_rvalid_b", 32'(rvalid_b), 32'd0);
    checkOutput("r036_rst_rdata_a",  32'(rdata_a),  32'd0);
    stepEdge();
    rst_n = 1'b1;
    settle();
    checkOutput("r036_no_rvalid_a", 32'(rvalid_a), 32'd0);
    checkOutput("r036_next_gnt_a",  32'(gnt_a),    32'd1);
    stepEdge();
    applyStimulus(idle, idle);
    settle();

    // Randomized traffic; a requester holds its request until the model says it was granted
    cur_a = idle;
    cur_b = idle;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stepEdge();
      if (!(cur_a.req && !mg_a)) cur_a = randReq();
      if (!(cur_b.req && !mg_b)) cur_b = randReq();
      applyStimulus(cur_a, cur_b);
      rst_n = ($urandom_range(0, 99) != 0);
    end
    stepEdge();
    rst_n = 1'b1;
    applyStimulus(idle, idle);
    settle();
    stepEdge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
